// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared command opcodes, response codes and FSM encodings for the host link
package comm_pkg;

   localparam int DEFAULT_BAUD_DIV = 2604;

   localparam logic [7:0] POS_ACK = 8'hA5;

   typedef enum logic [3:0] {
      OP_CAL_GYRO = 4'h2,
      OP_MOVE     = 4'h4,
      OP_TOUR     = 4'h6
   } opcode_e;

   localparam logic [15:0] CAL_GYRO = 16'h2000;

   // Tour command form is 16'h60XY: opcode, zero nibble, start square x/y.
   function automatic logic [15:0] tour_cmd(input logic [3:0] x, input logic [3:0] y);
      return {OP_TOUR, 4'h0, x, y};
   endfunction

   localparam logic [1:0] CMD_IDLE    = 2'd0;
   localparam logic [1:0] CMD_SEND_HI = 2'd1;
   localparam logic [1:0] CMD_SEND_LO = 2'd2;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex 8N1 transceiver, BAUD_DIV clocks per bit
module uart
   import comm_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_o,
   output logic       tx_done_o,
   input  logic       rx_i,
   input  logic       clr_rx_rdy_i,
   output logic       rx_rdy_o,
   output logic [7:0] rx_data_o
);

   localparam int BW = ($clog2(BAUD_DIV) + 1 > 12) ? $clog2(BAUD_DIV) + 1 : 12;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

   logic          tx_q;
   logic          tx_busy_q;
   logic [BW-1:0] tx_baud_q;
   logic [3:0]    tx_bit_q;
   logic [7:0]    tx_shift_q;
   logic          tx_end;

   assign tx_end    = tx_busy_q && (tx_baud_q == BAUD_LAST);
   // Combinational so the caller can chain the next frame with no idle gap.
   assign tx_done_o = tx_end && (tx_bit_q == 4'd9);
   assign tx_o      = tx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_baud_q  <= '0;
         tx_bit_q   <= 4'd0;
         tx_shift_q <= 8'h00;
      end else if (tx_start_i) begin
         tx_q       <= 1'b0;
         tx_busy_q  <= 1'b1;
         tx_baud_q  <= '0;
         tx_bit_q   <= 4'd0;
         tx_shift_q <= tx_data_i;
      end else if (tx_busy_q) begin
         if (tx_end) begin
            tx_baud_q <= '0;
            if (tx_bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
               tx_q      <= 1'b1;
            end else begin
               tx_bit_q   <= tx_bit_q + 4'd1;
               tx_q       <= (tx_bit_q == 4'd8) ? 1'b1 : tx_shift_q[0];
               tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
         end else begin
            tx_baud_q <= tx_baud_q + BW'(1);
         end
      end
   end

   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic [1:0]    rx_state_q;
   logic [BW-1:0] rx_baud_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic [7:0]    rx_data_q;
   logic          rx_rdy_q;
   logic          rx_fall;

   assign rx_fall   = rx_prev_q && !rx_s2_q;
   assign rx_rdy_o  = rx_rdy_q;
   assign rx_data_o = rx_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_baud_q  <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_rdy_q   <= 1'b0;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         if (clr_rx_rdy_i) rx_rdy_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_state_q <= RX_START;
                  rx_baud_q  <= '0;
                  rx_rdy_q   <= 1'b0;
               end
            end
            RX_START: begin
               if (rx_baud_q == HALF_LAST) begin
                  rx_baud_q  <= '0;
                  rx_bit_q   <= 3'd0;
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_baud_q <= rx_baud_q + BW'(1);
               end
            end
            RX_DATA: begin
               if (rx_baud_q == BAUD_LAST) begin
                  rx_baud_q  <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
               end else begin
                  rx_baud_q <= rx_baud_q + BW'(1);
               end
            end
            RX_STOP: begin
               // Byte is delivered at mid-stop regardless of the stop bit level.
               if (rx_baud_q == BAUD_LAST) begin
                  rx_baud_q  <= '0;
                  rx_data_q  <= rx_shift_q;
                  rx_rdy_q   <= 1'b1;
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_baud_q <= rx_baud_q + BW'(1);
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/remote_comm_host.sv
// rtl/remote_comm_host.sv - host command link: 16-bit command as two UART bytes, byte responses back
module remote_comm_host
   import comm_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd,
   input  logic        snd_cmd,
   output logic        TX,
   input  logic        RX,
   output logic        cmd_snt,
   output logic [7:0]  resp,
   output logic        resp_rdy
);

   logic [1:0] state_q, state_d;
   logic [7:0] hi_q, lo_q;
   logic       start_q;
   logic       cmd_snt_q;
   logic       accept;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;

   assign accept   = (state_q == CMD_IDLE) && snd_cmd;
   // High byte starts one cycle after accept; low byte chains on the high byte's last cycle.
   assign tx_start = start_q || ((state_q == CMD_SEND_HI) && tx_done);
   assign tx_data  = start_q ? hi_q : lo_q;
   assign cmd_snt  = cmd_snt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         CMD_IDLE:    if (accept) state_d = CMD_SEND_HI;
         CMD_SEND_HI: if (tx_done) state_d = CMD_SEND_LO;
         CMD_SEND_LO: if (tx_done) state_d = CMD_IDLE;
         default:     state_d = CMD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CMD_IDLE;
         hi_q      <= 8'h00;
         lo_q      <= 8'h00;
         start_q   <= 1'b0;
         cmd_snt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= accept;
         if (accept) begin
            hi_q      <= cmd[15:8];
            lo_q      <= cmd[7:0];
            cmd_snt_q <= 1'b0;
         end
         if ((state_q == CMD_SEND_LO) && tx_done) cmd_snt_q <= 1'b1;
      end
   end

   uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk_i        (clk),
      .rst_i        (rst),
      .tx_start_i   (tx_start),
      .tx_data_i    (tx_data),
      .tx_o         (TX),
      .tx_done_o    (tx_done),
      .rx_i         (RX),
      .clr_rx_rdy_i (accept),
      .rx_rdy_o     (resp_rdy),
      .rx_data_o    (resp)
   );

endmodule

// File: tb/tb_remote_comm_host.sv
// tb/tb_remote_comm_host.sv - directed self-checking bench for remote_comm_host
module tb_remote_comm_host;
   import comm_pkg::*;

   localparam int B = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cmd = 16'h0000;
   logic        snd_cmd = 1'b0;
   logic        tx;
   logic        rx;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        cmd_snt;
   logic [7:0]  resp;
   logic        resp_rdy;

   int checks = 0;
   int failures = 0;

   assign rx = loop ? tx : rx_drv;

   always #5 clk = ~clk;

   remote_comm_host #(.BAUD_DIV(B)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd),
      .snd_cmd  (snd_cmd),
      .TX       (tx),
      .RX       (rx),
      .cmd_snt  (cmd_snt),
      .resp     (resp),
      .resp_rdy (resp_rdy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends c and checks all 20 mid-bit TX samples against the expected frames of c.
   // With inject set, a second request c2 arrives 50 cycles in and must be ignored.
   task automatic send_cap(input string tag, input logic [15:0] c, input logic inject,
                           input logic [15:0] c2, output int snt_at);
      logic [19:0] frame;
      int j;
      frame  = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
      snt_at = -1;
      cmd = c;
      snd_cmd = 1'b1;
      tick(1);
      snd_cmd = 1'b0;
      check({tag, "_tx_idle_at_accept"}, 32'(tx), 32'd1);
      check({tag, "_rdy_cleared"}, 32'(resp_rdy), 32'd0);
      check({tag, "_snt_cleared"}, 32'(cmd_snt), 32'd0);
      for (int k = 1; k <= 20 * B + 10; k++) begin
         if (inject && k == 50) begin
            cmd = c2;
            snd_cmd = 1'b1;
         end
         tick(1);
         snd_cmd = 1'b0;
         if (((k - 1) % B) == (B / 2) && k <= 20 * B) begin
            j = (k - 1) / B;
            check($sformatf("%s_bit%0d", tag, j), 32'(tx), 32'(frame[j]));
         end
         if (snt_at < 0 && cmd_snt) snt_at = k;
      end
      check({tag, "_tx_idle_after"}, 32'(tx), 32'd1);
   endtask

   task automatic rx_send(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         rx_drv = frame[j];
         tick(B);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      int snt_at;
      int rises;
      int falls;
      logic prev;
      logic [7:0] got_resp [2];

      tick(2);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (i % 33 == 0) begin
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_snt", 32'(cmd_snt), 32'd0);
            check("rst_rdy", 32'(resp_rdy), 32'd0);
            check("rst_resp", 32'(resp), 32'h00);
         end
      end

      rx_drv = 1'b0;
      tick(3);
      rx_drv = 1'b1;
      tick(15 * B);
      check("false_start_rdy", 32'(resp_rdy), 32'd0);
      check("false_start_resp", 32'(resp), 32'h00);

      rx_send(POS_ACK);
      check("rx_ack_rdy", 32'(resp_rdy), 32'd1);
      check("rx_ack_resp", 32'(resp), 32'hA5);

      send_cap("c6022", 16'h6022, 1'b0, 16'h0000, snt_at);
      check("c6022_snt_cycle", 32'(snt_at), 32'd321);

      send_cap("busy", 16'h1234, 1'b1, 16'hFFFF, snt_at);
      check("busy_snt_cycle", 32'(snt_at), 32'd321);

      loop = 1'b1;
      cmd = 16'hA55A;
      snd_cmd = 1'b1;
      tick(1);
      snd_cmd = 1'b0;
      rises = 0;
      falls = 0;
      prev = resp_rdy;
      got_resp[0] = 8'h00;
      got_resp[1] = 8'h00;
      for (int k = 0; k < 24 * B; k++) begin
         tick(1);
         if (resp_rdy && !prev) begin
            if (rises < 2) got_resp[rises] = resp;
            rises++;
         end
         if (!resp_rdy && prev) falls++;
         prev = resp_rdy;
      end
      check("loop_rises", 32'(rises), 32'd2);
      check("loop_falls", 32'(falls), 32'd1);
      check("loop_resp0", 32'(got_resp[0]), 32'hA5);
      check("loop_resp1", 32'(got_resp[1]), 32'h5A);
      loop = 1'b0;
      tick(5);

      cmd = 16'hC3C3;
      snd_cmd = 1'b1;
      tick(1);
      snd_cmd = 1'b0;
      tick(3 * B + 3);
      check("mid_tx_low", 32'(tx), 32'd0);
      rst = 1'b1;
      tick(1);
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_snt", 32'(cmd_snt), 32'd0);
      rst = 1'b0;
      tick(5);
      check("post_rst_tx", 32'(tx), 32'd1);
      send_cap("post", 16'h0F5A, 1'b0, 16'h0000, snt_at);
      check("post_snt_cycle", 32'(snt_at), 32'd321);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
